// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the symmetric multi-channel FIR engine.
//   - DEF_COEF     : power-up / reset coefficient table (unique half, index 0..10)
//   - state_e      : engine FSM states
//   - clog2        : ceiling log2 usable in parameter expressions
//   - acc_width    : accumulator width that cannot overflow for H terms
//   - default_coef : table lookup returning 0 beyond the table
package fir_pkg;

  localparam int DEF_NCOEF = 11;
  localparam int DEF_COEF [DEF_NCOEF] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Pre-add grows one bit, the product adds CW bits and H accumulations add clog2(H).
  function automatic int acc_width(input int dw, input int cw, input int h);
    return dw + 1 + cw + clog2(h);
  endfunction

  function automatic int default_coef(input int idx);
    if (idx >= 0 && idx < DEF_NCOEF) return DEF_COEF[idx];
    return 0;
  endfunction

endpackage

// File: rtl/fir_preadd_mac.sv
// fir_preadd_mac: one pre-add / multiply / accumulate term per enabled cycle.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : zero the accumulator (has priority over en_i)
//   en_i          : add coef_i * (xa_i + xb_i) to the accumulator
//   xa_i, xb_i    : the two mirrored delay-line taps (unsigned)
//   coef_i        : shared coefficient for that tap pair (unsigned)
//   acc_o         : registered accumulator
module fir_preadd_mac #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int ACCW = 21
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [DW-1:0]   xa_i,
  input  logic [DW-1:0]   xb_i,
  input  logic [CW-1:0]   coef_i,
  output logic [ACCW-1:0] acc_o
);

  logic [DW:0]      pre;
  logic [DW+CW:0]   prod;
  logic [ACCW-1:0]  acc_q;
  logic [ACCW-1:0]  acc_d;

  assign pre  = {1'b0, xa_i} + {1'b0, xb_i};
  assign prod = {{CW{1'b0}}, pre} * {{(DW+1){1'b0}}, coef_i};

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACCW'(prod);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_sym_mc.sv
// fir_sym_mc: time-multiplexed symmetric FIR, one delay line per channel,
// one shared pre-add/MAC datapath, run-time programmable coefficients.
//   CLK_Filter, rst_n    : clock, synchronous active-low reset
//   in_valid/in_ready    : sample handshake; in_ch/in_data carry the sample
//   coef_we/addr/wdata   : coefficient write (taken only while idle)
//   clr                  : zero every delay line (taken only while idle)
//   out_valid            : one-cycle strobe with out_ch/out_data
//   bad_ch               : sticky, an out-of-range channel was presented
//   dbg_state            : current FSM state for observation
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is 1 only in IDLE; the source holds in_valid and the
// sample stable until the transfer. An out-of-range channel still transfers
// (is consumed) but is dropped and only sets bad_ch.
module fir_sym_mc
  import fir_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int NTAPS = 22,
  parameter  int DW    = 8,
  parameter  int CW    = 8,
  localparam int H     = NTAPS / 2,
  localparam int CHW   = (clog2(NCH) > 1) ? clog2(NCH) : 1,
  localparam int KW    = clog2(H),
  localparam int ACCW  = acc_width(DW, CW, H)
) (
  input  logic            CLK_Filter,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CHW-1:0]  in_ch,
  input  logic [DW-1:0]   in_data,
  input  logic            coef_we,
  input  logic [KW-1:0]   coef_addr,
  input  logic [CW-1:0]   coef_wdata,
  input  logic            clr,
  output logic            out_valid,
  output logic [CHW-1:0]  out_ch,
  output logic [ACCW-1:0] out_data,
  output logic            bad_ch,
  output state_e          dbg_state
);

  state_e           state_q, state_d;
  logic [CHW-1:0]   ch_q;
  logic [DW-1:0]    smp_q;
  logic [KW-1:0]    k_q;
  logic             out_valid_q;
  logic [CHW-1:0]   out_ch_q;
  logic [ACCW-1:0]  out_data_q;
  logic             bad_ch_q;
  logic [CW-1:0]    coef_q [H];
  logic [DW-1:0]    x_q [NCH][NTAPS];

  logic             accept;
  logic             take;
  logic             last_k;
  logic [ACCW-1:0]  acc;
  logic [DW-1:0]    line [NTAPS];
  logic [DW-1:0]    xa, xb;
  logic [CW-1:0]    cf;

  // Per-encoding "channel exists" table, so the range check never compares
  // in_ch against a constant it cannot reach.
  logic [(1<<CHW)-1:0] ch_ok;
  for (genvar g = 0; g < (1 << CHW); g++) begin : g_ch_ok
    assign ch_ok[g] = (g < NCH);
  end

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign take     = accept & ch_ok[in_ch];
  assign last_k   = (k_q == KW'(H - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (take) state_d = S_SHIFT;
      S_SHIFT: state_d = S_MAC;
      S_MAC:   if (last_k) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      smp_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      bad_ch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      if (take) begin
        ch_q  <= in_ch;
        smp_q <= in_data;
      end
      if (accept && !ch_ok[in_ch]) bad_ch_q <= 1'b1;
      if (state_q == S_SHIFT)              k_q <= '0;
      else if (state_q == S_MAC && !last_k) k_q <= k_q + 1'b1;
      if (state_q == S_OUT) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= ch_q;
        out_data_q  <= acc;
      end
    end
  end

  // Writes land on the accept edge, so a same-edge sample (first used two
  // edges later in MAC) already sees the new value.
  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++) coef_q[i] <= CW'(default_coef(i));
    end else if (state_q == S_IDLE && coef_we) begin
      for (int i = 0; i < H; i++)
        if (coef_addr == KW'(i)) coef_q[i] <= coef_wdata;
    end
  end

  // clr acts in IDLE while the shift happens one edge later in SHIFT, so a
  // sample accepted together with clr enters a zeroed line.
  always_ff @(posedge CLK_Filter) begin
    if (!rst_n || (state_q == S_IDLE && clr)) begin
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAPS; t++) x_q[c][t] <= '0;
    end else if (state_q == S_SHIFT) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_q == CHW'(c)) begin
          x_q[c][0] <= smp_q;
          for (int t = 1; t < NTAPS; t++) x_q[c][t] <= x_q[c][t-1];
        end
      end
    end
  end

  // Select the active channel's line, then the mirrored tap pair for term k.
  always_comb begin
    line = x_q[0];
    for (int c = 1; c < NCH; c++)
      if (ch_q == CHW'(c)) line = x_q[c];
    xa = '0;
    xb = '0;
    cf = '0;
    for (int i = 0; i < H; i++) begin
      if (k_q == KW'(i)) begin
        xa = line[i];
        xb = line[NTAPS-1-i];
        cf = coef_q[i];
      end
    end
  end

  fir_preadd_mac #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk_i  (CLK_Filter),
    .rst_ni (rst_n),
    .clr_i  (state_q == S_SHIFT),
    .en_i   (state_q == S_MAC),
    .xa_i   (xa),
    .xb_i   (xb),
    .coef_i (cf),
    .acc_o  (acc)
  );

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign bad_ch    = bad_ch_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fir_sym_mc.md
Name: fir_sym_mc

Overview:
Parametrised, multi-channel, symmetric-coefficient FIR filter for the pulse-oximeter front end. It replaces the per-colour fixed 22-tap filters with one time-multiplexed engine. Per-channel delay lines (default: ch0 = RED, ch1 = IR) share a single pre-add/multiply/accumulate datapath. The block sits between the ADC sample demux and the SpO2/heart-rate processing, with valid/ready input, a one-cycle output strobe, and run-time programmable coefficients.

Parameters:
NCH, 2, number of independent channels (each has its own delay line)
NTAPS, 22, filter length; must be even and >= 4
DW, 8, unsigned input sample width
CW, 8, unsigned coefficient width
H, NTAPS/2, derived: number of unique coefficients and MAC iterations
CHW, max(1, clog2(NCH)), derived: channel index width
ACCW, DW+1+CW+clog2(H), derived: accumulator/output width (21 at defaults)

Ports:
CLK_Filter  in  1  filter clock; single clock domain
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  sample present
in_ready  out  1  engine can accept a sample
in_ch  in  CHW  channel index of sample
in_data  in  DW  ADC sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(H)  coefficient index 0..H-1
coef_wdata  in  CW  coefficient value
clr  in  1  zero all delay lines
out_valid  out  1  one-cycle result strobe
out_ch  out  CHW  channel of result
out_data  out  ACCW  filtered result, full precision, unscaled
bad_ch  out  1  sticky flag: an out-of-range in_ch was presented

Behaviour:
- Reset: synchronous, applied on any CLK_Filter edge with rst_n=0, including mid-operation. State returns to IDLE, in_ready=1, out_valid=0, out_ch=0, out_data=0, bad_ch=0, all delay lines zeroed, coefficients reloaded from the package default table. An in-flight result is discarded.
- FSM states: IDLE -> SHIFT -> MAC -> OUT -> IDLE. in_ready = (state==IDLE).
- IDLE: on an edge with in_valid & in_ready, capture in_ch/in_data and go to SHIFT. If in_ch >= NCH, the sample is consumed and dropped, bad_ch is set (cleared only by reset), and state stays IDLE.
- SHIFT: delay line of the captured channel shifts (x[0] <= sample, x[i] <= x[i-1]). acc <= 0, k <= 0. Go to MAC. Other channels are untouched.
- MAC: one term per edge: acc += coef[k] * (x[k] + x[NTAPS-1-k]). The pre-add is DW+1 bits and all arithmetic is unsigned. When k==H-1 go to OUT; otherwise k++.
- OUT: out_data <= final acc, out_ch <= channel, out_valid <= 1 for exactly one cycle. Go to IDLE.
- Latency: accept edge E0. out_valid is high in the cycle after edge E0+H+2 (13 at defaults). in_ready rises together with out_valid. Maximum throughput is one sample per H+3 cycles. in_valid is ignored while in_ready=0; the upstream source holds it.
- Overflow: cannot occur. ACCW covers H * (2*(2^DW-1)) * (2^CW-1).
- Coefficient writes: honoured only on edges where state==IDLE; ignored otherwise. If coef_we and a sample accept occur on the same edge, the new coefficient applies to that sample. coef_addr >= H is ignored.
- clr: honoured only in IDLE. It zeroes every delay line. If clr and a sample accept occur on the same edge, clearing happens first and the new sample lands in x[0] of a zeroed line. clr does not affect coefficients or bad_ch.
- Default coefficients (index 0..10): 2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128 (sum 693).

Decomposition:
- Package fir_pkg: default coefficient table constant, FSM state enum, clog2 function, and the derived-width helper for ACCW.
- Sub-module fir_preadd_mac: registered acc with clear, one pre-add/multiply/accumulate term per enable. Delay-line storage, coefficient RAM and FSM stay in fir_sym_mc.

Test Plan:
- Impulse: ch0 receives 1, then 21 zeros. out_data sequence is 2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128, 128, 122, ..., 2, then 0. out_ch=0 every time, and the out_valid to in_ready timing is exactly H+3 cycles per sample.
- DC plus channel isolation: ch0 receives 255 x 22 while interleaved ch1 receives 0 x 22. Final ch0 out_data = 353430; every ch1 out_data = 0.
- Coefficient write: write coef[10]=0 in IDLE, then send an impulse on ch1. Outputs 11 and 12 become 0 and the rest are unchanged. A write attempted during MAC has no effect.
- Reset mid-MAC: assert rst_n=0 for 1 cycle during MAC. No out_valid follows, in_ready=1 next cycle, and the next impulse reproduces the default sequence from zeroed history.
- Bad channel and clr: in_ch=NCH gives bad_ch=1 (sticky), no out_valid, and no delay-line change. Then clr followed by sample 5 on ch0 gives out_data = 10.
- Back-pressure: hold in_valid high continuously. Exactly one accept per H+3 cycles and no sample is lost or duplicated; check against a scoreboard.
